// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI mode-0 master shift engine with lead/lag slave-select timing
module spi_shift_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  ss_n
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_LAG   = 2'd3;

    localparam int               BIT_W       = $clog2(DATA_WIDTH + 1);
    localparam logic [7:0]       HALF_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH);

    logic [1:0]            state;
    logic [7:0]            half_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic [DATA_WIDTH-1:0] rx_shifted;

    // Next shift-register values; written as whole-vector shifts so DATA_WIDTH=1 elaborates cleanly
    assign tx_shifted = tx_sr << 1;
    assign rx_shifted = (rx_sr << 1) | DATA_WIDTH'(miso);

    // Transfer sequencer: every output is a register updated here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            half_cnt <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            ss_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_sr    <= tx_data;
                        rx_sr    <= '0;
                        mosi     <= tx_data[DATA_WIDTH-1];
                        ss_n     <= 1'b0;
                        busy     <= 1'b1;
                        half_cnt <= HALF_RELOAD;
                        bit_cnt  <= '0;
                        state    <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (half_cnt == 8'd0) begin
                        // First rising sclk edge also captures the first miso bit
                        sclk     <= 1'b1;
                        rx_sr    <= rx_shifted;
                        bit_cnt  <= bit_cnt + 1'b1;
                        half_cnt <= HALF_RELOAD;
                        state    <= ST_SHIFT;
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (half_cnt != 8'd0) begin
                        half_cnt <= half_cnt - 1'b1;
                    end else begin
                        half_cnt <= HALF_RELOAD;
                        if (!sclk) begin
                            sclk    <= 1'b1;
                            rx_sr   <= rx_shifted;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                mosi  <= 1'b0;
                                state <= ST_LAG;
                            end else begin
                                tx_sr <= tx_shifted;
                                mosi  <= tx_shifted[DATA_WIDTH-1];
                            end
                        end
                    end
                end
                ST_LAG: begin
                    if (half_cnt == 8'd0) begin
                        ss_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        state   <= ST_IDLE;
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - randomized self-checking bench for spi_shift_engine
module tb_spi_shift_engine;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int          sel;
    int          W;
    int          D;
    logic [31:0] mask;
    logic        start_v;
    logic [31:0] tx_v;
    logic        loop;
    logic        slave_bit;

    logic        start_a, busy_a, done_a, sclk_a, mosi_a, miso_a, ss_n_a;
    logic [7:0]  rx_a;
    logic        start_b, busy_b, done_b, sclk_b, mosi_b, miso_b, ss_n_b;
    logic [31:0] rx_b;

    logic        o_ss, o_sclk, o_mosi, o_busy, o_done;
    logic [31:0] o_rx;

    int errors = 0;
    int checks = 0;

    assign start_a = (sel == 0) && start_v;
    assign start_b = (sel == 1) && start_v;
    assign miso_a  = loop ? mosi_a : slave_bit;
    assign miso_b  = loop ? mosi_b : slave_bit;

    spi_shift_engine #(.DATA_WIDTH(8), .CLK_DIV(2)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .tx_data(tx_v[7:0]),
        .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a),
        .mosi(mosi_a), .miso(miso_a), .ss_n(ss_n_a)
    );

    spi_shift_engine #(.DATA_WIDTH(32), .CLK_DIV(1)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .tx_data(tx_v),
        .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b),
        .mosi(mosi_b), .miso(miso_b), .ss_n(ss_n_b)
    );

    // Route the selected instance to one set of observation signals
    always_comb begin
        if (sel == 0) begin
            o_ss = ss_n_a; o_sclk = sclk_a; o_mosi = mosi_a;
            o_busy = busy_a; o_done = done_a; o_rx = {24'h0, rx_a};
        end else begin
            o_ss = ss_n_b; o_sclk = sclk_b; o_mosi = mosi_b;
            o_busy = busy_b; o_done = done_b; o_rx = rx_b;
        end
    end

    task automatic set_sel(input int s);
        sel  = s;
        W    = (s == 1) ? 32 : 8;
        D    = (s == 1) ? 1 : 2;
        mask = (s == 1) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endtask

    // Observe one transfer; start is expected to have been driven before the coming edge
    task automatic xfer(input logic [31:0] tx, input logic [31:0] sw, input logic [31:0] exp_rx,
                        input bit hold, input int poke_k, input string tag);
        int k = 0, nr = 0, ss_low = 0, idx = 0, t0_k = -1, done_off = -1;
        int bad_time = 0, bad_mosi = 0, bad_busy = 0;
        int budget = 2 * D * W + D + 12;
        logic prev_sclk = 1'b0;
        logic [31:0] rx_seen = 32'h0;
        bit fin = 1'b0;
        slave_bit = sw[W-1];
        while (!fin && k < budget) begin
            @(negedge clk);
            k++;
            if (!hold) begin
                start_v = (k == poke_k);
                tx_v    = (k == poke_k) ? 32'h0000_00FF : $urandom;
            end
            if (o_ss == 1'b0) begin
                if (t0_k < 0) t0_k = k;
                ss_low++;
                if (o_busy !== 1'b1) bad_busy++;
            end
            if (!prev_sclk && o_sclk) begin
                if (k - t0_k != D + 2 * D * nr) bad_time++;
                if (nr < W && o_mosi !== tx[W-1-nr]) bad_mosi++;
                nr++;
            end
            if (prev_sclk && !o_sclk) begin
                idx++;
                if (idx < W) slave_bit = sw[W-1-idx];
            end
            if (o_done === 1'b1) begin
                fin      = 1'b1;
                rx_seen  = o_rx;
                done_off = k - t0_k;
                if (o_ss !== 1'b1) bad_busy++;
            end
            prev_sclk = o_sclk;
        end
        checks++; if (!fin) begin errors++; $display("FAIL %s timeout: no done in %0d cycles", tag, budget); end
        checks++; if (t0_k != 1) begin errors++; $display("FAIL %s t0_latency: got %0d want 1", tag, t0_k); end
        checks++; if (done_off != 2 * D * W + D) begin errors++; $display("FAIL %s done_time: got %0d want %0d", tag, done_off, 2 * D * W + D); end
        checks++; if (ss_low != 2 * D * W + D) begin errors++; $display("FAIL %s ss_low: got %0d want %0d", tag, ss_low, 2 * D * W + D); end
        checks++; if (nr != W) begin errors++; $display("FAIL %s sclk_rises: got %0d want %0d", tag, nr, W); end
        checks++; if (bad_time != 0) begin errors++; $display("FAIL %s rise_timing: got %0d misplaced want 0", tag, bad_time); end
        checks++; if (bad_mosi != 0) begin errors++; $display("FAIL %s mosi_bits: got %0d wrong want 0", tag, bad_mosi); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL %s busy_ss: got %0d bad cycles want 0", tag, bad_busy); end
        checks++; if (rx_seen !== exp_rx) begin errors++; $display("FAIL %s rx_data: got %h want %h", tag, rx_seen, exp_rx); end
    endtask

    task automatic check_idle_after(input logic [31:0] exp_rx, input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_ss !== 1'b1 || o_sclk !== 1'b0) begin
                errors++;
                $display("FAIL %s idle[%0d]: done=%b busy=%b ss_n=%b sclk=%b want 0 0 1 0",
                         tag, i, o_done, o_busy, o_ss, o_sclk);
            end
        end
        checks++;
        if (o_rx !== exp_rx) begin errors++; $display("FAIL %s rx_hold: got %h want %h", tag, o_rx, exp_rx); end
    endtask

    task automatic run_one(input logic [31:0] tx, input logic [31:0] sw, input logic [31:0] exp_rx,
                           input int poke_k, input string tag);
        @(negedge clk);
        start_v = 1'b1;
        tx_v    = tx;
        xfer(tx, sw, exp_rx & mask, 1'b0, poke_k, tag);
        start_v = 1'b0;
        check_idle_after(exp_rx & mask, tag);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start_v = 1'b0; tx_v = 32'h0; loop = 1'b1; slave_bit = 1'b0;
        set_sel(0);
        repeat (2) @(negedge clk);
        checks++;
        if ({ss_n_a, sclk_a, mosi_a, busy_a, done_a} !== 5'b10000 || rx_a !== 8'h0) begin
            errors++; $display("FAIL reset_a: ss/sclk/mosi/busy/done=%b rx=%h want 10000 00", {ss_n_a, sclk_a, mosi_a, busy_a, done_a}, rx_a);
        end
        checks++;
        if ({ss_n_b, sclk_b, mosi_b, busy_b, done_b} !== 5'b10000 || rx_b !== 32'h0) begin
            errors++; $display("FAIL reset_b: ss/sclk/mosi/busy/done=%b rx=%h want 10000 0", {ss_n_b, sclk_b, mosi_b, busy_b, done_b}, rx_b);
        end
        reset_n = 1'b1;
        check_idle_after(32'h0, "reset_idle");
    endtask

    task automatic test_loopback_a5;
        set_sel(0); loop = 1'b1;
        run_one(32'hA5, 32'h0, 32'hA5, -1, "loop_a5");
    endtask

    task automatic test_slave_w32;
        set_sel(1); loop = 1'b0;
        run_one(32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, -1, "w32_slave");
    endtask

    task automatic test_ignored_start;
        set_sel(0); loop = 1'b1;
        run_one(32'h96, 32'h0, 32'h96, 5, "ignore_start");
    endtask

    task automatic test_back_to_back;
        set_sel(0); loop = 1'b1;
        @(negedge clk);
        start_v = 1'b1;
        tx_v    = 32'h3C;
        for (int n = 0; n < 3; n++) xfer(32'h3C, 32'h0, 32'h3C, 1'b1, -1, $sformatf("b2b%0d", n));
        start_v = 1'b0;
        check_idle_after(32'h3C, "b2b_end");
    endtask

    task automatic test_random;
        logic [31:0] t, s;
        for (int n = 0; n < 6; n++) begin
            set_sel(n % 2);
            loop = 1'b0;
            t = $urandom;
            s = $urandom;
            run_one(t, s, s, ((n % 3) == 0) ? 3 : -1, $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_mid_reset;
        set_sel(0); loop = 1'b1;
        @(negedge clk);
        start_v = 1'b1;
        tx_v    = $urandom;
        repeat (10) begin
            @(negedge clk);
            start_v = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ss_n_a, sclk_a, mosi_a, busy_a} !== 4'b1000) begin
            errors++; $display("FAIL midrst_outputs: ss/sclk/mosi/busy=%b want 1000", {ss_n_a, sclk_a, mosi_a, busy_a});
        end
        checks++;
        if (rx_a !== 8'h0 || rx_b !== 32'h0) begin
            errors++; $display("FAIL midrst_rx: got %h/%h want 0/0", rx_a, rx_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done_a !== 1'b0 || ss_n_a !== 1'b1) begin
                errors++; $display("FAIL midrst_hold[%0d]: done=%b ss_n=%b want 0 1", i, done_a, ss_n_a);
            end
        end
        reset_n = 1'b1;
        run_one(32'h5B, 32'h0, 32'h5B, -1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_loopback_a5();
        test_slave_w32();
        test_ignored_start();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
